// File: rtl/inst_encoder_if.sv
// Command/FIFO bus for the instruction encoder.
//   master : host + FIFO side (drives the command fields and fifo_full)
//   slave  : encoder side (drives cmd_ready, the FIFO write, count, clip flag)
interface inst_encoder_if #(
    parameter int CNT_W = 16
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic             inst_type;
    logic             vertice_num;
    logic [47:0]      coordinates;
    logic             layer_num;
    logic             fill_type;
    logic [23:0]      color_code;
    logic [1:0]       texture_code;
    logic [3:0]       alpha_val;
    logic             fifo_full;
    logic             fifo_wen;
    logic [81:0]      fifo_wdata;
    logic [CNT_W-1:0] inst_count;
    logic             alpha_clip;

    modport master (
        output cmd_valid, inst_type, vertice_num, coordinates, layer_num,
               fill_type, color_code, texture_code, alpha_val, fifo_full,
        input  cmd_ready, fifo_wen, fifo_wdata, inst_count, alpha_clip
    );

    modport slave (
        input  cmd_valid, inst_type, vertice_num, coordinates, layer_num,
               fill_type, color_code, texture_code, alpha_val, fifo_full,
        output cmd_ready, fifo_wen, fifo_wdata, inst_count, alpha_clip
    );
endinterface

// File: rtl/inst_encoder.sv
// Instruction encoder and FIFO writer for the 2D GPU command path.
// Packs one shape or alpha command per handshake into an 82-bit word, holds
// it, and writes it to the instruction FIFO when fifo_full is low.
// Ports:
//   clk   - system clock
//   n_rst - asynchronous active-low reset
//   bus   - inst_encoder_if.slave: command fields + valid/ready, FIFO
//           write strobe/data/full, issued-word count, sticky alpha clip
//
// state | meaning
// IDLE  | no word pending, ready for a command
// PEND  | hold register contains a word awaiting a FIFO write
module inst_encoder #(
    parameter int CNT_W = 16
) (
    input  logic           clk,
    input  logic           n_rst,
    inst_encoder_if.slave  bus
);
    typedef enum logic {IDLE = 1'b0, PEND = 1'b1} state_t;

    state_t           state_q, state_d;
    logic [81:0]      hold_q, hold_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             clip_q, clip_d;
    logic [81:0]      enc;
    logic             write;
    logic             accept;

    // Only the fields of the selected format reach the word.
    always_comb begin
        enc = '0;
        if (bus.inst_type) begin
            enc[0]   = 1'b1;
            enc[3:1] = bus.alpha_val[2:0];
        end else begin
            enc[1]     = bus.vertice_num;
            enc[17:2]  = bus.coordinates[47:32];
            enc[33:18] = bus.coordinates[31:16];
            if (bus.vertice_num)
                enc[49:34] = bus.coordinates[15:0];
            enc[50] = bus.layer_num;
            enc[51] = bus.fill_type;
            if (bus.fill_type)
                enc[77:76] = bus.texture_code;
            else
                enc[75:52] = bus.color_code;
            enc[81:78] = bus.alpha_val;
        end
    end

    // Ready/write depend only on state and fifo_full, never on cmd_valid.
    assign write         = (state_q == PEND) && !bus.fifo_full;
    assign bus.fifo_wen  = write;
    assign bus.cmd_ready = (state_q == IDLE) || !bus.fifo_full;
    assign accept        = bus.cmd_valid && bus.cmd_ready;

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        if (accept) begin
            state_d = PEND;
            hold_d  = enc;
        end else if (write) begin
            state_d = IDLE;
        end
        count_d = count_q + {{(CNT_W-1){1'b0}}, write};
        clip_d  = clip_q | (accept && bus.inst_type && bus.alpha_val[3]);
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= IDLE;
            hold_q  <= '0;
            count_q <= '0;
            clip_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            count_q <= count_d;
            clip_q  <= clip_d;
        end
    end

    assign bus.fifo_wdata = hold_q;
    assign bus.inst_count = count_q;
    assign bus.alpha_clip = clip_q;
endmodule

// File: doc/inst_encoder.md
# inst_encoder

Instruction encoder and FIFO writer for the 2D GPU command path. It accepts one structured draw or alpha command per handshake and packs it into the 82-bit instruction word format that the decode stage unpacks. It then writes the word into the instruction FIFO under full-flag backpressure. It sits between the host command interface and the instruction FIFO, and it also keeps a count of issued instructions.

## Interface
- CNT_W, 16, width of the issued-instruction counter
- clk  in  1  system clock; all state updates on the rising edge
- n_rst  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command fields valid this cycle
- cmd_ready  out  1  encoder can accept a command this cycle
- inst_type  in  1  0 = shape instruction, 1 = alpha instruction
- vertice_num  in  1  0 = 2 vertices, 1 = 3 vertices (shape only)
- coordinates  in  48  {v1[15:0], v2[15:0], v3[15:0]}, v1 in [47:32]
- layer_num  in  1  target layer (shape only)
- fill_type  in  1  0 = solid color, 1 = texture (shape only)
- color_code  in  24  RGB fill color (solid only)
- texture_code  in  2  texture select (texture only)
- alpha_val  in  4  alpha value
- fifo_full  in  1  instruction FIFO cannot take a write
- fifo_wen  out  1  FIFO write strobe; one word per high cycle
- fifo_wdata  out  82  encoded instruction word
- inst_count  out  CNT_W  number of words written since reset
- alpha_clip  out  1  sticky: an alpha instruction had alpha_val[3]=1

## Operation
- Encoding for shape instructions (inst_type=0):
  - [0]=0, [1]=vertice_num
  - [17:2]=coordinates[47:32], [33:18]=coordinates[31:16]
  - [49:34]=coordinates[15:0] if vertice_num=1, else 0
  - [50]=layer_num, [51]=fill_type
  - [75:52]=color_code if fill_type=0, else 0
  - [77:76]=texture_code if fill_type=1, else 0
  - [81:78]=alpha_val
- Encoding for alpha instructions (inst_type=1):
  - [0]=1, [3:1]=alpha_val[2:0], all other bits 0.
  - alpha_val[3] is dropped. If it is 1, alpha_clip sets and stays set until reset.
- Encoded word is registered into a hold register on accept. fifo_wdata is always the hold register.
- FSM states:
  - IDLE: no word pending. cmd_ready=1, fifo_wen=0. On accept (cmd_valid=1), load hold and go to PEND.
  - PEND: word pending. fifo_wen = !fifo_full and cmd_ready = !fifo_full.
- PEND transitions:
  - fifo_full=1: stay in PEND, hold unchanged, no write.
  - fifo_full=0 with cmd_valid=1: the current word is written and the new command is loaded into hold in the same edge. Stay in PEND.
  - fifo_full=0 with cmd_valid=0: write the current word and go to IDLE.
- inst_count increments by 1 on every cycle with fifo_wen=1 and wraps modulo 2^CNT_W.
- Fields irrelevant to the selected format are ignored; they never leak into the word.

## Timing
- Reset values (async, n_rst=0): state=IDLE, hold=0 (fifo_wdata=0), fifo_wen=0, cmd_ready=1, inst_count=0, alpha_clip=0.
- Latency: a command accepted at edge N appears on fifo_wdata after edge N, with fifo_wen=1 during cycle N+1 if fifo_full=0 in that cycle.
- Throughput: one word per cycle while fifo_full=0 and cmd_valid stays high.
- fifo_wen and cmd_ready are combinational from state and fifo_full only. No combinational path from cmd_valid to any output.
- The producer must hold its fields stable while cmd_valid=1 and cmd_ready=0.
- fifo_full rising while a word is pending: the word is held indefinitely, with no loss and no duplicate write.
- Reset asserted in PEND: the pending word is discarded and no write occurs.

## Test plan
- Reset behaviour: after reset, expect cmd_ready=1, fifo_wen=0, fifo_wdata=0, inst_count=0, alpha_clip=0.
- 3-vertex solid shape: send v1=0x0010, v2=0x0020, v3=0x0030, layer=1, fill=0, color=0xFF8000, alpha=0xA. Next cycle expect fifo_wen=1 and a word with [81:78]=0xA, [75:52]=0xFF8000, [51]=0, [50]=1, [49:34]=0x0030, [33:18]=0x0020, [17:2]=0x0010, [1]=1, [0]=0.
- 2-vertex textured shape: send texture=2'b11 with garbage in color_code and v3. Expect [77:76]=3, [75:52]=0, [49:34]=0.
- Alpha instruction with alpha_val=0xD: expect word 82'h0 with [3:1]=3'b101 and [0]=1, and alpha_clip=1 (still 1 after 10 idle cycles).
- Backpressure: hold fifo_full=1 for 5 cycles after an accept. Expect cmd_ready=0, fifo_wen=0 and fifo_wdata stable throughout. Deasserting fifo_full gives exactly one write.
- Streaming: 8 back-to-back commands with fifo_full=0. Expect 8 consecutive fifo_wen pulses in order and inst_count=8. With CNT_W=3, inst_count wraps to 0.
